clint_ctrl: RTL and testbench

- Core-local interrupt/trap sequencer. It is the initiator side of the CSR file's clint write/read port.
- Detects ECALL, EBREAK, MRET and the timer interrupt, stalls the pipeline, and performs the CSR update sequence (mepc, mstatus, mcause) one write per cycle.
- Issues a one-cycle redirect to mtvec on trap entry, or to mepc on MRET.
- Sits between the id/ex stages, the CSR file and the pipeline-control (hold/jump) logic.

---
 rtl/clint_ctrl.sv | 139 +++++++++++++
 tb/tb_clint_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// clint_ctrl: trap/interrupt sequencer driving CSR writes and pipeline redirect (option: CLINT_EXT_INT_EN)
module clint_ctrl #(
    parameter int DATA_W = 32,
    parameter int CSR_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [DATA_W-1:0] inst_addr_i,
    input  logic              inst_valid_i,
    input  logic [7:0]        int_flag_i,
    input  logic              global_int_en_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    output logic              we_o,
    output logic [CSR_AW-1:0] waddr_o,
    output logic [CSR_AW-1:0] raddr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              hold_flag_o,
    output logic              int_assert_o,
    output logic [DATA_W-1:0] int_addr_o
);
    localparam logic [DATA_W-1:0] ECALL  = DATA_W'(32'h0000_0073);
    localparam logic [DATA_W-1:0] EBREAK = DATA_W'(32'h0010_0073);
    localparam logic [DATA_W-1:0] MRET   = DATA_W'(32'h3020_0073);
    localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);

    typedef enum logic [2:0] {IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cause_q, cause_d, pc_q, pc_d;
    logic              we_q, we_d, int_assert_q, int_assert_d;
    logic [CSR_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] data_q, data_d, int_addr_q, int_addr_d;
    logic              ev_ecall, ev_ebreak, ev_timer, ev_ext, ev_mret, ev_trap;
    logic [DATA_W-1:0] trap_cause, trap_mstatus, mret_mstatus;

    assign ev_ecall  = inst_valid_i && inst_i == ECALL;
    assign ev_ebreak = inst_valid_i && inst_i == EBREAK;
    assign ev_timer  = inst_valid_i && int_flag_i[0] && global_int_en_i;
    assign ev_mret   = inst_valid_i && inst_i == MRET;
`ifdef CLINT_EXT_INT_EN
    logic unused_flags;
    assign unused_flags = ^int_flag_i[7:2];
    assign ev_ext = inst_valid_i && int_flag_i[1] && global_int_en_i;
`else
    logic unused_flags;
    assign unused_flags = ^int_flag_i[7:1];
    assign ev_ext = 1'b0;
`endif
    assign ev_trap    = ev_ecall | ev_ebreak | ev_timer | ev_ext;
    assign trap_cause = ev_ecall  ? DATA_W'(32'd11) :
                        ev_ebreak ? DATA_W'(32'd3) :
                        ev_timer  ? DATA_W'(32'h8000_0007) : DATA_W'(32'h8000_000B);

    // Trap entry saves MIE into MPIE and clears MIE; MRET restores MIE and sets MPIE
    assign trap_mstatus = {csr_mstatus_i[DATA_W-1:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
    assign mret_mstatus = {csr_mstatus_i[DATA_W-1:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};

    assign hold_flag_o  = (state_q != IDLE) || ev_trap || ev_mret;
    assign raddr_o      = A_MSTATUS;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign data_o       = data_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;

    // Next state plus next output values, so registered outputs line up with the state they belong to
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        we_d         = 1'b0;
        waddr_d      = '0;
        data_d       = '0;
        int_assert_d = 1'b0;
        int_addr_d   = '0;
        case (state_q)
            IDLE: begin
                if (ev_trap) begin
                    state_d = W_MEPC;
                    cause_d = trap_cause;
                    pc_d    = inst_addr_i;
                    we_d    = 1'b1;
                    waddr_d = A_MEPC;
                    data_d  = inst_addr_i;
                end else if (ev_mret) begin
                    state_d      = W_MRET;
                    we_d         = 1'b1;
                    waddr_d      = A_MSTATUS;
                    data_d       = mret_mstatus;
                    int_assert_d = 1'b1;
                    int_addr_d   = csr_mepc_i;
                end
            end
            W_MEPC: begin
                state_d = W_MSTATUS;
                we_d    = 1'b1;
                waddr_d = A_MSTATUS;
                data_d  = trap_mstatus;
            end
            W_MSTATUS: begin
                state_d      = W_MCAUSE;
                we_d         = 1'b1;
                waddr_d      = A_MCAUSE;
                data_d       = cause_q;
                int_assert_d = 1'b1;
                int_addr_d   = csr_mtvec_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched trap info and output registers; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cause_q      <= '0;
            pc_q         <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            pc_q         <= pc_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
        end
    end
endmodule

// File: tb/tb_clint_ctrl.sv
// tb_clint_ctrl: directed self-checking bench for clint_ctrl
module tb_clint_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] inst_i = '0, inst_addr_i = '0, csr_mtvec_i = '0, csr_mepc_i = '0, csr_mstatus_i = '0;
    logic        inst_valid_i = 1'b0, global_int_en_i = 1'b0;
    logic [7:0]  int_flag_i = '0;
    logic        we_o, hold_flag_o, int_assert_o;
    logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;
    int          n_chk = 0, n_fail = 0;

    localparam logic [31:0] ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073, MRET = 32'h3020_0073, NOP = 32'h0000_0013;

    clint_ctrl dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
        .int_flag_i(int_flag_i), .global_int_en_i(global_int_en_i), .csr_mtvec_i(csr_mtvec_i),
        .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i), .we_o(we_o), .waddr_o(waddr_o),
        .raddr_o(raddr_o), .data_o(data_o), .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_out(input string tag);
        chk({tag, ".we"}, 32'(we_o), 32'd0);
        chk({tag, ".waddr"}, waddr_o, 32'd0);
        chk({tag, ".data"}, data_o, 32'd0);
        chk({tag, ".int_assert"}, 32'(int_assert_o), 32'd0);
        chk({tag, ".int_addr"}, int_addr_o, 32'd0);
    endtask

    // Called just after inputs that raise a trap were applied at a negedge
    task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [31:0] mst, input logic [31:0] cause, input logic [31:0] vec);
        #1 chk({tag, ".hold_detect"}, 32'(hold_flag_o), 32'd1);
        @(negedge clk);
        inst_valid_i = 1'b0;
        chk({tag, ".mepc_we"}, 32'(we_o), 32'd1);
        chk({tag, ".mepc_addr"}, waddr_o, 32'h341);
        chk({tag, ".mepc_data"}, data_o, pc);
        chk({tag, ".mepc_hold"}, 32'(hold_flag_o), 32'd1);
        chk({tag, ".mepc_noassert"}, 32'(int_assert_o), 32'd0);
        @(negedge clk);
        chk({tag, ".mst_addr"}, waddr_o, 32'h300);
        chk({tag, ".mst_data"}, data_o, mst);
        chk({tag, ".mst_hold"}, 32'(hold_flag_o), 32'd1);
        @(negedge clk);
        chk({tag, ".mcause_we"}, 32'(we_o), 32'd1);
        chk({tag, ".mcause_addr"}, waddr_o, 32'h342);
        chk({tag, ".mcause_data"}, data_o, cause);
        chk({tag, ".assert"}, 32'(int_assert_o), 32'd1);
        chk({tag, ".int_addr"}, int_addr_o, vec);
        chk({tag, ".mcause_hold"}, 32'(hold_flag_o), 32'd1);
        @(negedge clk);
        idle_out({tag, ".after"});
        chk({tag, ".after_hold"}, 32'(hold_flag_o), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        idle_out("reset");
        chk("reset.hold", 32'(hold_flag_o), 32'd0);
        chk("reset.raddr", raddr_o, 32'h300);
        rst = 1'b0;
        @(negedge clk);

        // ECALL at 0x100
        inst_i = ECALL; inst_addr_i = 32'h100; inst_valid_i = 1'b1; csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
        trap_seq("ecall", 32'h100, 32'h80, 32'd11, 32'h200);

        // MRET back to 0x104
        inst_i = MRET; inst_valid_i = 1'b1; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80;
        #1 chk("mret.hold_detect", 32'(hold_flag_o), 32'd1);
        @(negedge clk);
        inst_valid_i = 1'b0;
        chk("mret.we", 32'(we_o), 32'd1);
        chk("mret.waddr", waddr_o, 32'h300);
        chk("mret.data", data_o, 32'h88);
        chk("mret.assert", 32'(int_assert_o), 32'd1);
        chk("mret.int_addr", int_addr_o, 32'h104);
        chk("mret.hold", 32'(hold_flag_o), 32'd1);
        @(negedge clk);
        idle_out("mret.after");
        chk("mret.after_hold", 32'(hold_flag_o), 32'd0);

        // EBREAK
        inst_i = EBREAK; inst_addr_i = 32'h180; inst_valid_i = 1'b1; csr_mstatus_i = 32'h88;
        trap_seq("ebreak", 32'h180, 32'h80, 32'd3, 32'h200);

        // Timer with MIE = 1
        inst_i = NOP; inst_addr_i = 32'h300; inst_valid_i = 1'b1; int_flag_i = 8'h01; global_int_en_i = 1'b1; csr_mstatus_i = 32'h8;
        trap_seq("timer", 32'h300, 32'h80, 32'h8000_0007, 32'h200);

        // Timer with MIE = 0 is ignored
        inst_valid_i = 1'b1; global_int_en_i = 1'b0;
        #1 chk("timer_masked.hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        chk("timer_masked.we", 32'(we_o), 32'd0);

        // Bubble with timer enabled is not a trap point
        inst_valid_i = 1'b0; global_int_en_i = 1'b1;
        #1 chk("timer_bubble.hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);

        // ECALL and timer together: ECALL wins
        inst_i = ECALL; inst_addr_i = 32'h400; inst_valid_i = 1'b1; csr_mstatus_i = 32'h8;
        trap_seq("ecall_timer", 32'h400, 32'h80, 32'd11, 32'h200);
        inst_i = NOP; inst_valid_i = 1'b1; global_int_en_i = 1'b0; csr_mstatus_i = 32'h80;
        #1 chk("ecall_timer.no_retrap_hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        chk("ecall_timer.no_retrap_we", 32'(we_o), 32'd0);

        // MRET with timer pending and MIE = 0
        inst_i = MRET; csr_mepc_i = 32'h404;
        @(negedge clk);
        inst_valid_i = 1'b0;
        chk("mret_pend.data", data_o, 32'h88);
        chk("mret_pend.int_addr", int_addr_o, 32'h404);
        int_flag_i = 8'h00;
        @(negedge clk);

        // Reset in W_MSTATUS aborts
        inst_i = ECALL; inst_addr_i = 32'h500; inst_valid_i = 1'b1; csr_mstatus_i = 32'h8;
        @(negedge clk);
        inst_valid_i = 1'b0;
        @(negedge clk);
        chk("abort.in_mstatus", waddr_o, 32'h300);
        rst = 1'b1;
        @(negedge clk);
        idle_out("abort.reset");
        chk("abort.hold", 32'(hold_flag_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.no_mcause_we", 32'(we_o), 32'd0);
        chk("abort.no_mcause_hold", 32'(hold_flag_o), 32'd0);

        // External interrupt line
        inst_i = NOP; inst_addr_i = 32'h600; inst_valid_i = 1'b1; int_flag_i = 8'h02; global_int_en_i = 1'b1; csr_mstatus_i = 32'h8;
`ifdef CLINT_EXT_INT_EN
        trap_seq("ext", 32'h600, 32'h80, 32'h8000_000B, 32'h200);
`else
        #1 chk("ext_off.hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        chk("ext_off.we", 32'(we_o), 32'd0);
`endif
        inst_valid_i = 1'b0; int_flag_i = 8'h00;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
